// File: rtl/ra_pkg.sv
// Shared definitions for the ra_2r1w_cfg register-file array slice.
// Optional feature macro: RA_PARITY_EN (enables per-entry parity storage/check).
package ra_pkg;

  // Default geometry, matching the original fixed 64x72 array wrapper.
  localparam int RA_WIDTH_DEF  = 72;
  localparam int RA_ADDR_W_DEF = 6;

  // Widest data word the parity helper accepts; narrower words are zero-padded.
  localparam int RA_PAR_MAX_W  = 1024;

  // Post-reset initialisation sequencer states.
  typedef enum logic [1:0] {
    RA_IDLE  = 2'd0,
    RA_CLEAR = 2'd1,
    RA_READY = 2'd2
  } ra_init_state_e;

  // Even parity (XOR reduction) of a zero-padded data word.
  function automatic logic ra_parity(input logic [RA_PAR_MAX_W-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/ra_init_seq.sv
// Post-reset initialisation sequencer for ra_2r1w_cfg.
// Walks a clear address from 0 to DEPTH-1 (one entry per cycle) when
// INIT_CLEAR is set, then raises init_done. The counter stops at DEPTH-1.
module ra_init_seq
  import ra_pkg::*;
#(
  parameter int ADDR_W     = RA_ADDR_W_DEF,
  parameter int INIT_CLEAR = 1
) (
  input  logic              clk,
  input  logic              reset,
  output logic              clr_en,
  output logic [ADDR_W-1:0] clr_adr,
  output logic              init_done
);

  localparam logic [ADDR_W-1:0] LAST_ADR = {ADDR_W{1'b1}};

  ra_init_state_e    state, state_nxt;
  logic [ADDR_W-1:0] cnt, cnt_nxt;

  // State and clear-counter registers; reset always restarts from IDLE/0.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RA_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state, counter advance and clear-write/ready outputs.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    clr_en    = 1'b0;
    init_done = 1'b0;
    case (state)
      RA_IDLE: begin
        cnt_nxt = '0;
        if (INIT_CLEAR != 0) state_nxt = RA_CLEAR;
        else                 state_nxt = RA_READY;
      end
      RA_CLEAR: begin
        clr_en = 1'b1;
        if (cnt == LAST_ADR) state_nxt = RA_READY;
        else                 cnt_nxt   = cnt + 1'b1;
      end
      RA_READY: begin
        init_done = 1'b1;
      end
      default: begin
        state_nxt = RA_IDLE;
      end
    endcase
  end

  assign clr_adr = cnt;

endmodule

// File: rtl/ra_2r1w_cfg.sv
// Parametrised 2-read/1-write register-file array with latched inputs,
// write-to-read bypass, read-valid outputs and a post-reset clear sequence.
// Optional feature macro: RA_PARITY_EN adds a stored parity bit per entry,
// a per-write parity inject input and per-port parity-error outputs.
module ra_2r1w_cfg
  import ra_pkg::*;
#(
  parameter int WIDTH      = RA_WIDTH_DEF,
  parameter int ADDR_W     = RA_ADDR_W_DEF,
  parameter int LATCHRD    = 1,
  parameter int INIT_CLEAR = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_enb_0,
  input  logic [0:ADDR_W-1] rd_adr_0,
  output logic [0:WIDTH-1]  rd_dat_0,
  output logic              rd_vld_0,
  input  logic              rd_enb_1,
  input  logic [0:ADDR_W-1] rd_adr_1,
  output logic [0:WIDTH-1]  rd_dat_1,
  output logic              rd_vld_1,
  input  logic              wr_enb_0,
  input  logic [0:ADDR_W-1] wr_adr_0,
  input  logic [0:WIDTH-1]  wr_dat_0,
`ifdef RA_PARITY_EN
  output logic              rd_perr_0,
  output logic              rd_perr_1,
  input  logic              wr_par_inj,
`endif
  output logic              init_done
);

  localparam int DEPTH = 2 ** ADDR_W;

  // Stage-1 request registers
  logic              s1_rd_enb_0, s1_rd_enb_1, s1_wr_enb;
  logic [0:ADDR_W-1] s1_rd_adr_0, s1_rd_adr_1, s1_wr_adr;
  logic [0:WIDTH-1]  s1_wr_dat;

  // Clear sequencer interface
  logic              clr_en;
  logic [ADDR_W-1:0] clr_adr;

  // Storage and read mux
  logic [0:WIDTH-1]  mem_dat [DEPTH];
  logic              hit_0, hit_1;
  logic [0:WIDTH-1]  mux_dat_0, mux_dat_1;

  ra_init_seq #(
    .ADDR_W     (ADDR_W),
    .INIT_CLEAR (INIT_CLEAR)
  ) u_init_seq (
    .clk       (clk),
    .reset     (reset),
    .clr_en    (clr_en),
    .clr_adr   (clr_adr),
    .init_done (init_done)
  );

  // Capture requests; enables are masked until the array is ready.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_rd_enb_0 <= 1'b0;
      s1_rd_enb_1 <= 1'b0;
      s1_wr_enb   <= 1'b0;
      s1_rd_adr_0 <= '0;
      s1_rd_adr_1 <= '0;
      s1_wr_adr   <= '0;
    end else begin
      s1_rd_enb_0 <= rd_enb_0 & init_done;
      s1_rd_enb_1 <= rd_enb_1 & init_done;
      s1_wr_enb   <= wr_enb_0 & init_done;
      s1_rd_adr_0 <= rd_adr_0;
      s1_rd_adr_1 <= rd_adr_1;
      s1_wr_adr   <= wr_adr_0;
    end
  end

  // Write data carries no reset; it is only consumed alongside s1_wr_enb.
  always_ff @(posedge clk) begin
    s1_wr_dat <= wr_dat_0;
  end

  // Array write at the end of stage 1; the clear walk owns the array until ready.
  always_ff @(posedge clk) begin
    if (clr_en)         mem_dat[clr_adr]   <= '0;
    else if (s1_wr_enb) mem_dat[s1_wr_adr] <= s1_wr_dat;
  end

  // Read mux with independent per-port bypass of same-cycle write data.
  always_comb begin
    hit_0     = s1_wr_enb & s1_rd_enb_0 & (s1_wr_adr == s1_rd_adr_0);
    hit_1     = s1_wr_enb & s1_rd_enb_1 & (s1_wr_adr == s1_rd_adr_1);
    mux_dat_0 = hit_0 ? s1_wr_dat : mem_dat[s1_rd_adr_0];
    mux_dat_1 = hit_1 ? s1_wr_dat : mem_dat[s1_rd_adr_1];
  end

`ifdef RA_PARITY_EN
  logic s1_par_inj;
  logic s1_wr_par;
  logic mem_par [DEPTH];
  logic mux_perr_0, mux_perr_1;

  function automatic logic [RA_PAR_MAX_W-1:0] pad_par(input logic [0:WIDTH-1] d);
    logic [RA_PAR_MAX_W-1:0] p;
    p            = '0;
    p[WIDTH-1:0] = d;
    return p;
  endfunction

  // Inject flag travels with the write data.
  always_ff @(posedge clk) begin
    s1_par_inj <= wr_par_inj;
  end

  assign s1_wr_par = ra_parity(pad_par(s1_wr_dat)) ^ s1_par_inj;

  // Parity store mirrors the data store; cleared entries get parity of zero.
  always_ff @(posedge clk) begin
    if (clr_en)         mem_par[clr_adr]   <= 1'b0;
    else if (s1_wr_enb) mem_par[s1_wr_adr] <= s1_wr_par;
  end

  // Recompute parity on the (possibly bypassed) read data and flag a mismatch.
  always_comb begin
    mux_perr_0 = s1_rd_enb_0 &
                 (ra_parity(pad_par(mux_dat_0)) != (hit_0 ? s1_wr_par : mem_par[s1_rd_adr_0]));
    mux_perr_1 = s1_rd_enb_1 &
                 (ra_parity(pad_par(mux_dat_1)) != (hit_1 ? s1_wr_par : mem_par[s1_rd_adr_1]));
  end
`endif

  generate
    if (LATCHRD != 0) begin : g_latched
      // Registered read outputs; data holds its last value while not valid.
      always_ff @(posedge clk) begin
        if (reset) begin
          rd_dat_0 <= '0;
          rd_dat_1 <= '0;
          rd_vld_0 <= 1'b0;
          rd_vld_1 <= 1'b0;
        end else begin
          rd_vld_0 <= s1_rd_enb_0;
          rd_vld_1 <= s1_rd_enb_1;
          if (s1_rd_enb_0) rd_dat_0 <= mux_dat_0;
          if (s1_rd_enb_1) rd_dat_1 <= mux_dat_1;
        end
      end
`ifdef RA_PARITY_EN
      // Parity error follows the same registered timing as the data.
      always_ff @(posedge clk) begin
        if (reset) begin
          rd_perr_0 <= 1'b0;
          rd_perr_1 <= 1'b0;
        end else begin
          rd_perr_0 <= mux_perr_0;
          rd_perr_1 <= mux_perr_1;
        end
      end
`endif
    end else begin : g_flow
      assign rd_dat_0 = mux_dat_0;
      assign rd_dat_1 = mux_dat_1;
      assign rd_vld_0 = s1_rd_enb_0;
      assign rd_vld_1 = s1_rd_enb_1;
`ifdef RA_PARITY_EN
      assign rd_perr_0 = mux_perr_0;
      assign rd_perr_1 = mux_perr_1;
`endif
    end
  endgenerate

endmodule

// File: tb/tb_ra_2r1w_cfg.sv
// Directed self-checking bench for ra_2r1w_cfg.
// Instance dut: default 64x72, LATCHRD=1, INIT_CLEAR=1.
// Instance dut_b: 8x8, LATCHRD=0, INIT_CLEAR=1.
// Parity checks are compiled in when RA_PARITY_EN is defined.
module tb_ra_2r1w_cfg;

  logic clk = 1'b0;
  logic reset;

  // Instance A
  logic        rd_enb_0, rd_enb_1, wr_enb_0;
  logic [0:5]  rd_adr_0, rd_adr_1, wr_adr_0;
  logic [0:71] wr_dat_0, rd_dat_0, rd_dat_1;
  logic        rd_vld_0, rd_vld_1, init_done;
`ifdef RA_PARITY_EN
  logic        rd_perr_0, rd_perr_1, wr_par_inj;
`endif

  // Instance B
  logic        b_rd_enb_0, b_rd_enb_1, b_wr_enb_0;
  logic [0:2]  b_rd_adr_0, b_rd_adr_1, b_wr_adr_0;
  logic [0:7]  b_wr_dat_0, b_rd_dat_0, b_rd_dat_1;
  logic        b_rd_vld_0, b_rd_vld_1, b_init_done;
`ifdef RA_PARITY_EN
  logic        b_rd_perr_0, b_rd_perr_1, b_wr_par_inj;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  ra_2r1w_cfg dut (
    .clk       (clk),
    .reset     (reset),
    .rd_enb_0  (rd_enb_0),
    .rd_adr_0  (rd_adr_0),
    .rd_dat_0  (rd_dat_0),
    .rd_vld_0  (rd_vld_0),
    .rd_enb_1  (rd_enb_1),
    .rd_adr_1  (rd_adr_1),
    .rd_dat_1  (rd_dat_1),
    .rd_vld_1  (rd_vld_1),
    .wr_enb_0  (wr_enb_0),
    .wr_adr_0  (wr_adr_0),
    .wr_dat_0  (wr_dat_0),
`ifdef RA_PARITY_EN
    .rd_perr_0 (rd_perr_0),
    .rd_perr_1 (rd_perr_1),
    .wr_par_inj(wr_par_inj),
`endif
    .init_done (init_done)
  );

  ra_2r1w_cfg #(
    .WIDTH      (8),
    .ADDR_W     (3),
    .LATCHRD    (0),
    .INIT_CLEAR (1)
  ) dut_b (
    .clk       (clk),
    .reset     (reset),
    .rd_enb_0  (b_rd_enb_0),
    .rd_adr_0  (b_rd_adr_0),
    .rd_dat_0  (b_rd_dat_0),
    .rd_vld_0  (b_rd_vld_0),
    .rd_enb_1  (b_rd_enb_1),
    .rd_adr_1  (b_rd_adr_1),
    .rd_dat_1  (b_rd_dat_1),
    .rd_vld_1  (b_rd_vld_1),
    .wr_enb_0  (b_wr_enb_0),
    .wr_adr_0  (b_wr_adr_0),
    .wr_dat_0  (b_wr_dat_0),
`ifdef RA_PARITY_EN
    .rd_perr_0 (b_rd_perr_0),
    .rd_perr_1 (b_rd_perr_1),
    .wr_par_inj(b_wr_par_inj),
`endif
    .init_done (b_init_done)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  // Drive one cycle of instance-A inputs, then move to the next falling edge.
  task automatic applyStimulus(input logic re0, input logic [5:0] ra0,
                               input logic re1, input logic [5:0] ra1,
                               input logic we, input logic [5:0] wa,
                               input logic [71:0] wd);
    rd_enb_0 = re0; rd_adr_0 = ra0;
    rd_enb_1 = re1; rd_adr_1 = ra1;
    wr_enb_0 = we;  wr_adr_0 = wa; wr_dat_0 = wd;
    @(negedge clk);
  endtask

  // Same for instance B.
  task automatic applyStimulusB(input logic re0, input logic [2:0] ra0,
                                input logic re1, input logic [2:0] ra1,
                                input logic we, input logic [2:0] wa,
                                input logic [7:0] wd);
    b_rd_enb_0 = re0; b_rd_adr_0 = ra0;
    b_rd_enb_1 = re1; b_rd_adr_1 = ra1;
    b_wr_enb_0 = we;  b_wr_adr_0 = wa; b_wr_dat_0 = wd;
    @(negedge clk);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int nb;
    logic [71:0] ab_pat;
    ab_pat = {9{8'hAB}};

    reset = 1'b1;
    rd_enb_0 = 0; rd_adr_0 = '0; rd_enb_1 = 0; rd_adr_1 = '0;
    wr_enb_0 = 0; wr_adr_0 = '0; wr_dat_0 = '0;
    b_rd_enb_0 = 0; b_rd_adr_0 = '0; b_rd_enb_1 = 0; b_rd_adr_1 = '0;
    b_wr_enb_0 = 0; b_wr_adr_0 = '0; b_wr_dat_0 = '0;
`ifdef RA_PARITY_EN
    wr_par_inj = 1'b0;
    b_wr_par_inj = 1'b0;
`endif
    repeat (3) @(negedge clk);

    // Reset state
    $display("[TB] reset state");
    checkOutput("rst_init_done", 128'(init_done), 128'(0));
    checkOutput("rst_vld0", 128'(rd_vld_0), 128'(0));
    checkOutput("rst_vld1", 128'(rd_vld_1), 128'(0));
    checkOutput("rst_dat0", 128'(rd_dat_0), 128'(0));
    checkOutput("rst_dat1", 128'(rd_dat_1), 128'(0));
`ifdef RA_PARITY_EN
    checkOutput("rst_perr0", 128'(rd_perr_0), 128'(0));
`endif

    // Release reset; A ready after 65 cycles, B (DEPTH 8) after 9.
    // B port 0 requests a read throughout early init, which must be masked.
    $display("[TB] init sequence");
    b_rd_enb_0 = 1'b1; b_rd_adr_0 = 3'd1;
    reset = 1'b0;
    n = 0; nb = 0;
    while (!init_done && n < 200) begin
      @(negedge clk);
      n++;
      if (b_init_done && nb == 0) nb = n;
      if (n == 4) checkOutput("b_vld_during_init", 128'(b_rd_vld_0), 128'(0));
      if (n == 5) b_rd_enb_0 = 1'b0;
    end
    checkOutput("a_init_latency", 128'(n), 128'(65));
    checkOutput("b_init_latency", 128'(nb), 128'(9));

    // Every entry reads zero after the clear walk.
    $display("[TB] read-all after clear");
    for (int i = 0; i < 64; i++) begin
      applyStimulus(1, 6'(i), 1, 6'(63 - i), 0, 6'd0, 72'd0);
      applyStimulus(0, 6'd0, 0, 6'd0, 0, 6'd0, 72'd0);
      checkOutput("clr_dat0", 128'(rd_dat_0), 128'(0));
      checkOutput("clr_dat1", 128'(rd_dat_1), 128'(0));
      if (i == 0) checkOutput("clr_vld0", 128'(rd_vld_0), 128'(1));
    end

    // Basic write then read, two-cycle read latency.
    $display("[TB] basic write/read");
    applyStimulus(0, 6'd0, 0, 6'd0, 1, 6'd5, ab_pat);
    applyStimulus(1, 6'd5, 0, 6'd0, 0, 6'd0, 72'd0);
    checkOutput("basic_vld_early", 128'(rd_vld_0), 128'(0));
    applyStimulus(0, 6'd0, 0, 6'd0, 0, 6'd0, 72'd0);
    checkOutput("basic_dat0", 128'(rd_dat_0), 128'(ab_pat));
    checkOutput("basic_vld0", 128'(rd_vld_0), 128'(1));
    applyStimulus(0, 6'd0, 0, 6'd0, 0, 6'd0, 72'd0);
    checkOutput("hold_vld0", 128'(rd_vld_0), 128'(0));
    checkOutput("hold_dat0", 128'(rd_dat_0), 128'(ab_pat));

    // Collision bypass on both ports.
    $display("[TB] collision bypass");
    applyStimulus(0, 6'd0, 0, 6'd0, 1, 6'd9, 72'h777);
    applyStimulus(1, 6'd9, 1, 6'd9, 1, 6'd9, 72'h123);
    applyStimulus(0, 6'd0, 0, 6'd0, 0, 6'd0, 72'd0);
    checkOutput("byp_dat0", 128'(rd_dat_0), 128'h123);
    checkOutput("byp_dat1", 128'(rd_dat_1), 128'h123);
    checkOutput("byp_vld1", 128'(rd_vld_1), 128'(1));
    // Port 0 bypasses a new write while port 1 reads stored data.
    applyStimulus(1, 6'd10, 1, 6'd9, 1, 6'd10, 72'h456);
    applyStimulus(0, 6'd0, 0, 6'd0, 0, 6'd0, 72'd0);
    checkOutput("byp_split_dat0", 128'(rd_dat_0), 128'h456);
    checkOutput("byp_split_dat1", 128'(rd_dat_1), 128'h123);

    // Unlatched instance: one-cycle latency and combinational bypass.
    $display("[TB] unlatched instance");
    applyStimulusB(0, 3'd0, 0, 3'd0, 1, 3'd2, 8'h5A);
    applyStimulusB(1, 3'd2, 0, 3'd0, 0, 3'd0, 8'h00);
    checkOutput("b_dat0", 128'(b_rd_dat_0), 128'h5A);
    checkOutput("b_vld0", 128'(b_rd_vld_0), 128'(1));
    applyStimulusB(0, 3'd0, 1, 3'd2, 1, 3'd2, 8'h33);
    checkOutput("b_byp_dat1", 128'(b_rd_dat_1), 128'h33);
    checkOutput("b_byp_vld1", 128'(b_rd_vld_1), 128'(1));
    checkOutput("b_idle_vld0", 128'(b_rd_vld_0), 128'(0));
    applyStimulusB(0, 3'd0, 0, 3'd0, 0, 3'd0, 8'h00);

    // Reset in the middle of the clear walk restarts it from address 0.
    $display("[TB] reset mid-clear");
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (21) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("midclr_init_done", 128'(init_done), 128'(0));
    reset = 1'b0;
    n = 0;
    while (!init_done && n < 200) begin
      @(negedge clk);
      n++;
      if (n == 11) begin
        wr_enb_0 = 1'b1; wr_adr_0 = 6'd3; wr_dat_0 = '1;
      end
      if (n == 12) wr_enb_0 = 1'b0;
    end
    checkOutput("reinit_latency", 128'(n), 128'(65));
    applyStimulus(1, 6'd3, 1, 6'd5, 0, 6'd0, 72'd0);
    applyStimulus(0, 6'd0, 0, 6'd0, 0, 6'd0, 72'd0);
    checkOutput("dropped_wr_dat0", 128'(rd_dat_0), 128'(0));
    checkOutput("recleared_dat1", 128'(rd_dat_1), 128'(0));

`ifdef RA_PARITY_EN
    // Parity inject produces a read error; a clean rewrite clears it.
    $display("[TB] parity");
    wr_par_inj = 1'b1;
    applyStimulus(0, 6'd0, 0, 6'd0, 1, 6'd3, 72'h0F0F);
    wr_par_inj = 1'b0;
    applyStimulus(1, 6'd3, 0, 6'd0, 0, 6'd0, 72'd0);
    applyStimulus(0, 6'd0, 0, 6'd0, 0, 6'd0, 72'd0);
    checkOutput("perr_inj", 128'(rd_perr_0), 128'(1));
    applyStimulus(0, 6'd0, 0, 6'd0, 0, 6'd0, 72'd0);
    checkOutput("perr_idle", 128'(rd_perr_0), 128'(0));
    applyStimulus(0, 6'd0, 0, 6'd0, 1, 6'd3, 72'h0F0F);
    applyStimulus(1, 6'd3, 0, 6'd0, 0, 6'd0, 72'd0);
    applyStimulus(0, 6'd0, 0, 6'd0, 0, 6'd0, 72'd0);
    checkOutput("perr_clean", 128'(rd_perr_0), 128'(0));
    wr_par_inj = 1'b1;
    applyStimulus(0, 6'd0, 1, 6'd4, 1, 6'd4, 72'h1);
    wr_par_inj = 1'b0;
    applyStimulus(0, 6'd0, 0, 6'd0, 0, 6'd0, 72'd0);
    checkOutput("perr_bypass", 128'(rd_perr_1), 128'(1));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ra_2r1w_cfg.md
Name: ra_2r1w_cfg

Overview:
- Parametrised successor of the fixed 64x72 two-read/one-write register-file array wrapper.
- Provides a DEPTH x WIDTH array with two independent read ports and one write port, all inputs latched.
- Adds write-to-read bypass on address collision, read-valid outputs, and a post-reset clear sequencer.
- Sits between core logic and behavioural storage; a later release may map onto toysram macro tiles.

Parameters:
- WIDTH, 72, data bits per entry (>=1).
- ADDR_W, 6, address bits; DEPTH = 2**ADDR_W entries.
- LATCHRD, 1, 1 = registered read data (latency 2); 0 = unlatched (latency 1).
- INIT_CLEAR, 1, 1 = zero every entry after reset; 0 = no clear, array contents undefined.

Ports:
- clk  in  1  clock; all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- rd_enb_0  in  1  read port 0 request.
- rd_adr_0  in  [0:ADDR_W-1]  read port 0 address.
- rd_dat_0  out  [0:WIDTH-1]  read port 0 data.
- rd_vld_0  out  1  rd_dat_0 valid this cycle.
- rd_enb_1, rd_adr_1, rd_dat_1, rd_vld_1: as port 0.
- wr_enb_0  in  1  write request.
- wr_adr_0  in  [0:ADDR_W-1]  write address.
- wr_dat_0  in  [0:WIDTH-1]  write data.
- init_done  out  1  array ready; requests are honoured only while high.
- rd_perr_0, rd_perr_1  out  1  parity error (RA_PARITY_EN only).
- wr_par_inj  in  1  invert stored parity bit on this write (RA_PARITY_EN only).

Behaviour:
- Stage 1: all enb/adr/wr_dat are registered. Reset clears the registered enables and addresses to 0.
- Array read (combinational from the stage-1 address) and write (at the end of the stage-1 cycle) both act in stage 1.
- Bypass: if stage-1 wr_enb and rd_enb_n are both set and addresses match, read port n returns the stage-1 wr_dat (new data), not the stored value. Each read port bypasses independently; both ports may hit together.
- LATCHRD=1:
  - rd_dat_n and rd_vld_n are registered; rd_vld_n = stage-1 rd_enb_n.
  - Request at cycle T gives data at T+2.
  - rd_dat_n holds its last value while rd_vld_n=0.
- LATCHRD=0: rd_dat_n is the mux output at T+1, and rd_vld_n = stage-1 rd_enb_n.
- Reset values: rd_dat_n=0 (LATCHRD=1), rd_vld_n=0, init_done=0, rd_perr_n=0.
- Init FSM states are IDLE, CLEAR, READY.
  - Reset forces IDLE.
  - IDLE -> CLEAR on the first non-reset cycle if INIT_CLEAR=1; otherwise IDLE -> READY.
  - CLEAR writes 0 (with correct parity) to address cnt, cnt = 0..DEPTH-1, one entry per cycle.
  - CLEAR -> READY after writing DEPTH-1. init_done=1 only in READY.
  - INIT_CLEAR=1: init_done rises DEPTH+1 cycles after reset deasserts.
- While init_done=0: incoming rd_enb and wr_enb are masked at stage-1 capture, so reads give rd_vld=0 and writes are dropped.
- Reset mid-CLEAR restarts the sequence from address 0.
- Reset does not alter array contents except via CLEAR.
- Address wrap: the counter stops at DEPTH-1 and does not wrap.

Optional Feature:
- Macro: RA_PARITY_EN.
- Defined:
  - Each entry stores WIDTH+1 bits; bit WIDTH = XOR of the data, inverted when stage-1 wr_par_inj=1.
  - On read (including bypass), the parity is recomputed. rd_perr_n is asserted alongside rd_vld_n on mismatch, with the same latency as rd_dat_n.
  - rd_perr_n=0 whenever rd_vld_n=0.
- Undefined: no parity storage; rd_perr_0/1 and wr_par_inj ports do not exist.

Decomposition:
- Package ra_pkg holds:
  - the init state enum (RA_IDLE, RA_CLEAR, RA_READY);
  - the default WIDTH/ADDR_W constants;
  - the parity helper function.
- Sub-module ra_init_seq: init FSM plus clear-address counter. It outputs the clear-write enable, address and init_done.
- Storage, bypass and output staging stay in ra_2r1w_cfg.

Test Plan:
- Init, INIT_CLEAR=1, ADDR_W=6: release reset -> init_done=0 for 64 cycles, 1 on cycle 65; reading every address then returns 0.
- Basic, LATCHRD=1: write 0xAB..AB to addr 5 at T; read port 0 addr 5 at T+1 -> rd_dat_0=0xAB..AB with rd_vld_0=1 at T+3.
- Collision bypass: same cycle, write 0x123 to addr 9 and read both ports at addr 9 -> both ports return 0x123 (not the old value), 2 cycles later.
- LATCHRD=0, WIDTH=8, ADDR_W=3: read addr 2 (holding 0x5A) -> rd_dat_0=0x5A one cycle after the request; issuing a read during init gives rd_vld_0=0.
- Reset mid-CLEAR: assert reset at clear count 20 -> init_done stays 0 and the clear restarts at 0; a write issued during CLEAR is dropped and the location reads 0.
- RA_PARITY_EN: write addr 3 with wr_par_inj=1 -> reading addr 3 gives rd_perr_0=1; rewrite with inj=0 -> rd_perr_0=0.
